// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the queue entry layout, fetch state encoding and PC range check.
package instr_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam int          ENTRY_W      = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_st_t;

  // Word aligned and inside the imem window. The limit is
  // 33 bits wide so ADR_BITS=30 does not wrap to zero.
  function automatic logic pc_in_range(
    input logic [31:0] pc,
    input logic [31:0] base,
    input int unsigned adr_bits
  );
    logic [31:0] off;
    logic [32:0] lim;
    off = pc - base;
    lim = 33'd4 << adr_bits;
    return (pc[1:0] == 2'b00) && ({1'b0, off} < lim);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch bus: redirect in, imem address/data, decode handshake out.
// master = fetch controller, slave = memory/decode/execute side.
interface instr_fetch_ctrl_if;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_exc;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    input  imem_instr,
    input  out_ready,
    output imem_addr,
    output out_valid,
    output out_instr,
    output out_pc,
    output out_exc
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    output imem_instr,
    output out_ready,
    input  imem_addr,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_exc
  );

endinterface

// File: rtl/instr_fetch_ctrl_queue.sv
// DEPTH x 65-bit fetch FIFO; clear beats push, head is 0 when empty.
// Ports: clk, reset, i_push, i_pop, i_clear, i_din, o_count, o_valid, o_head.
module instr_fetch_ctrl_queue
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  fetch_entry_t               i_din,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_valid,
  output fetch_entry_t               o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_wp;
  logic [PW-1:0]  r_rp;
  logic [CW-1:0]  r_cnt;

  logic w_pop;
  logic w_push;
  logic w_full;

  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_pop  = i_pop & (r_cnt != '0);
  assign w_push = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset; validity lives in r_cnt.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wp] <= i_din;
  end

  assign o_count = r_cnt;
  assign o_valid = (r_cnt != '0);
  assign o_head  = o_valid ? r_mem[r_rp] : '0;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: owns the PC, reads imem, queues words for decode.
// Ports: clk, reset (async, active-high), bus (fetch bus master modport).
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADR_BITS = 10,
  parameter int          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_ctrl_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_pc;
  fetch_st_t     r_state;

  logic          w_ok;
  logic          w_pop;
  logic          w_push;
  logic          w_qvalid;
  logic [CW-1:0] w_cnt;
  fetch_entry_t  w_din;
  fetch_entry_t  w_head;

  assign w_ok  = pc_in_range(r_pc, RESET_PC, ADR_BITS);
  assign w_pop = w_qvalid & bus.out_ready;

  // A pop frees a slot in the same cycle, so a full
  // queue still streams one word per cycle.
  assign w_push = ~bus.redirect_valid
                & (r_state == ST_RUN)
                & ((w_cnt < CW'(DEPTH)) | w_pop);

  assign w_din.pc    = r_pc;
  assign w_din.instr = w_ok ? bus.imem_instr : 32'h0;
  assign w_din.exc   = ~w_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
    end else begin
      unique case (1'b1)
        bus.redirect_valid: begin
          r_pc    <= bus.redirect_pc;
          r_state <= ST_RUN;
        end
        w_push && w_ok: r_pc <= r_pc + 32'd4;
        // The faulting entry is the last one until redirect.
        w_push && !w_ok: r_state <= ST_HALT;
        default: ;
      endcase
    end
  end

  instr_fetch_ctrl_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (bus.redirect_valid),
    .i_din   (w_din),
    .o_count (w_cnt),
    .o_valid (w_qvalid),
    .o_head  (w_head)
  );

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = w_qvalid;
  assign bus.out_pc    = w_head.pc;
  assign bus.out_instr = w_head.instr;
  assign bus.out_exc   = w_head.exc;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] LIM = 32'h0000_4000;
  localparam logic [31:0] XM  = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(
    .RESET_PC (RPC),
    .ADR_BITS (10),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_instr = bus.imem_addr ^ XM;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = RPC;
  bit          m_halt = 1'b0;

  // Reference: a plain list of fetched words and a PC that walks
  // the legal imem window, stopping at the first bad address.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_pc = RPC;
        m_halt = 1'b0;
      end else begin
        bit   pop_now;
        bit   push_now;
        bit   ok;
        ent_t e;
        pop_now = (mq.size() > 0) && bus.out_ready;
        push_now = !bus.redirect_valid && !m_halt
                && (mq.size() < DEPTH || pop_now);
        if (bus.redirect_valid) begin
          mq.delete();
          m_pc = bus.redirect_pc;
          m_halt = 1'b0;
        end else begin
          if (pop_now) void'(mq.pop_front());
          if (push_now) begin
            ok = (m_pc % 4 == 0) && m_pc >= RPC && m_pc < LIM;
            e.pc = m_pc;
            e.instr = ok ? (m_pc ^ XM) : 32'h0;
            e.exc = !ok;
            mq.push_back(e);
            if (ok) m_pc = m_pc + 4;
            else m_halt = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [97:0] exp_vec();
    if (mq.size() > 0)
      return {1'b1, mq[0].pc, mq[0].instr, mq[0].exc, m_pc};
    return {1'b0, 32'h0, 32'h0, 1'b0, m_pc};
  endfunction

  function automatic logic [97:0] dut_vec();
    return {bus.out_valid, bus.out_pc, bus.out_instr,
            bus.out_exc, bus.imem_addr};
  endfunction

  task automatic drive(input bit rdy, input bit rv,
                       input logic [31:0] rpc);
    bus.out_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    n_chk++;
    if (dut_vec() !== {1'b0, 64'h0, 1'b0, RPC}) begin
      n_fail++;
      $display("FAIL reset_state got %h want %h",
               dut_vec(), {1'b0, 64'h0, 1'b0, RPC});
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC) begin
      n_fail++;
      $display("FAIL first_valid got v=%b pc=%h want v=1 pc=%h",
               bus.out_valid, bus.out_pc, RPC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] want;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      want = RPC + 32'(4 * i);
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== want
          || bus.out_instr !== (want ^ XM)) begin
        n_fail++;
        $display("FAIL stream%0d got v=%b pc=%h i=%h want pc=%h i=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr,
                 want, want ^ XM);
      end
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream_model got %h want %h",
                 dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] nxt;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_model got %h want %h",
                 dut_vec(), exp_vec());
      end
    end
    n_chk++;
    if (bus.out_pc !== RPC || bus.imem_addr !== RPC + 32'h8
        || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold got pc=%h addr=%h want %h %h",
               bus.out_pc, bus.imem_addr, RPC, RPC + 32'h8);
    end
    nxt = RPC;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== nxt) begin
        n_fail++;
        $display("FAIL resume_order got v=%b pc=%h want pc=%h",
                 bus.out_valid, bus.out_pc, nxt);
      end
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL resume_model got %h want %h",
                 dut_vec(), exp_vec());
      end
      nxt = nxt + 32'd4;
      drive(1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_redirect_full();
    drive(1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.imem_addr !== bus.out_pc + 8) begin
      n_fail++;
      $display("FAIL redir_full got v=%b addr=%h pc=%h",
               bus.out_valid, bus.imem_addr, bus.out_pc);
    end
    drive(1'b1, 1'b1, 32'h3100);
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h3100) begin
      n_fail++;
      $display("FAIL redir_gap got v=%b addr=%h want v=0 addr=3100",
               bus.out_valid, bus.imem_addr);
    end
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3100
        || bus.out_instr !== (32'h3100 ^ XM)) begin
      n_fail++;
      $display("FAIL redir_target got v=%b pc=%h want pc=3100",
               bus.out_valid, bus.out_pc);
    end
    n_chk++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL redir_model got %h want %h",
               dut_vec(), exp_vec());
    end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b1, 32'h3102);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3102
        || bus.out_instr !== 32'h0 || bus.out_exc !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_entry got v=%b pc=%h i=%h e=%b",
               bus.out_valid, bus.out_pc, bus.out_instr, bus.out_exc);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h3102) begin
        n_fail++;
        $display("FAIL misalign_halt got v=%b addr=%h want v=0 3102",
                 bus.out_valid, bus.imem_addr);
      end
    end
    drive(1'b1, 1'b1, RPC);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC
        || bus.out_exc !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_restart got v=%b pc=%h e=%b",
               bus.out_valid, bus.out_pc, bus.out_exc);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] seen[$];
    bit          last_exc;
    last_exc = 1'b0;
    drive(1'b1, 1'b1, 32'h3FF0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bound_model got %h want %h",
                 dut_vec(), exp_vec());
      end
      if (bus.out_valid === 1'b1) begin
        seen.push_back(bus.out_pc);
        last_exc = bus.out_exc;
      end
    end
    n_chk++;
    if (seen.size() != 5 || seen[seen.size()-1] !== LIM
        || last_exc !== 1'b1 || seen[3] !== 32'h3FFC) begin
      n_fail++;
      $display("FAIL bound_seq got n=%0d last_exc=%b want n=5 exc=1",
               seen.size(), last_exc);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 32'h3200);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== RPC) begin
      n_fail++;
      $display("FAIL async_rst got v=%b addr=%h want v=0 addr=%h",
               bus.out_valid, bus.imem_addr, RPC);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.out_valid !== 1'b1
          || bus.out_pc !== RPC + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL async_restart%0d got v=%b pc=%h want %h",
                 i, bus.out_valid, bus.out_pc, RPC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
      case ($urandom_range(0, 9))
        0:       tgt = 32'h3000 + {$urandom_range(0, 1023), 2'b00};
        1:       tgt = 32'h3FF0 + {$urandom_range(0, 3), 2'b00};
        2:       tgt = 32'h3000 + $urandom_range(0, 4095);
        3:       tgt = 32'h2FFC;
        default: tgt = 32'h3000 + {$urandom_range(0, 63), 2'b00};
      endcase
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 14) == 0, tgt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_boundary();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
